// File: rtl/vendor_dispense_ctrl_pkg.sv
// Shared types and constants for the coin vendor sequencer and its change pulser.
package vendor_dispense_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_VEND    = 2'b10,
        ST_CHANGE  = 2'b11
    } state_t;

    localparam int unsigned COIN5_VAL  = 5;
    localparam int unsigned COIN10_VAL = 10;
    localparam int unsigned CHANGE_VAL = 5;
    localparam int unsigned COIN_SUM_W = 5;

    // Registered single-bit outputs of the sequencer
    typedef struct packed {
        logic coin_en;
        logic coin_reject;
        logic vend_req;
        logic change_pulse;
        logic fault;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_OUT_RST = '{
        coin_en:      1'b1,
        coin_reject:  1'b0,
        vend_req:     1'b0,
        change_pulse: 1'b0,
        fault:        1'b0
    };

    // Value of the coins presented in one cycle; both slots together count as 15
    function automatic logic [COIN_SUM_W-1:0] coin_sum(input logic c5, input logic c10);
        logic [COIN_SUM_W-1:0] s;
        s = '0;
        if (c5)  s = s + COIN_SUM_W'(COIN5_VAL);
        if (c10) s = s + COIN_SUM_W'(COIN10_VAL);
        return s;
    endfunction

    function automatic logic is_open(input state_t s);
        return (s == ST_IDLE) || (s == ST_COLLECT);
    endfunction

endpackage

// File: rtl/vendor_change_pulser.sv
// Change-return cadence: alternates pulse and gap cycles while active, and
// supplies the decremented credit and the last-coin indication to the sequencer.
module vendor_change_pulser
    import vendor_dispense_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                active,
    input  logic [CREDIT_W-1:0] credit,
    output logic                pulse_c,
    output logic [CREDIT_W-1:0] credit_dec_c,
    output logic                done_c
);

    logic gap;

    // Entry always begins on a pulse cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            gap <= 1'b0;
        end else if (start) begin
            gap <= 1'b0;
        end else if (active) begin
            gap <= ~gap;
        end
    end

    assign pulse_c      = active & ~gap;
    assign credit_dec_c = credit - CREDIT_W'(CHANGE_VAL);
    assign done_c       = pulse_c && (credit <= CREDIT_W'(CHANGE_VAL));

endmodule

// File: rtl/vendor_dispense_ctrl.sv
// Coin vendor sequencer: credit accumulation, dispense req/ack with timeout,
// and change return through the pulser sub-block.
module vendor_dispense_ctrl
    import vendor_dispense_ctrl_pkg::*;
#(
    parameter int unsigned PRICE       = 15,
    parameter int unsigned MAX_CREDIT  = 40,
    parameter int unsigned CREDIT_W    = 6,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                coin_en,
    output logic                coin_reject,
    output logic                vend_req,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                fault
);

    localparam int unsigned SUM_W   = CREDIT_W + 1;
    localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT + 1);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic [TIMER_W-1:0]  timer, timer_n;
    ctrl_out_t           out_q, out_n;

    logic [SUM_W-1:0]    coin_total_c;
    logic [CREDIT_W-1:0] credit_acc_c;
    logic                coin_any_c;
    logic                coin_fit_c;
    logic                pulse_c;
    logic                pulse_done_c;
    logic                pulse_start_c;
    logic [CREDIT_W-1:0] credit_dec_c;

    vendor_change_pulser #(
        .CREDIT_W (CREDIT_W)
    ) u_change_pulser (
        .clk          (clk),
        .rst          (rst),
        .start        (pulse_start_c),
        .active       (state == ST_CHANGE),
        .credit       (credit_q),
        .pulse_c      (pulse_c),
        .credit_dec_c (credit_dec_c),
        .done_c       (pulse_done_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            credit_q <= '0;
            timer    <= '0;
            out_q    <= CTRL_OUT_RST;
        end else begin
            state    <= state_n;
            credit_q <= credit_n;
            timer    <= timer_n;
            out_q    <= out_n;
        end
    end

    always_comb begin
        state_n            = state;
        credit_n           = credit_q;
        timer_n            = '0;
        out_n              = CTRL_OUT_RST;
        out_n.fault        = out_q.fault;
        pulse_start_c      = 1'b0;
        credit_acc_c       = credit_q;

        coin_any_c   = coin5 | coin10;
        coin_total_c = SUM_W'(credit_q) + SUM_W'(coin_sum(coin5, coin10));
        coin_fit_c   = (coin_total_c <= SUM_W'(MAX_CREDIT));

        case (state)
            ST_IDLE, ST_COLLECT: begin
                // Coins are applied before cancel so a same-cycle coin can still buy
                if (coin_any_c) begin
                    if (coin_fit_c) begin
                        credit_acc_c = CREDIT_W'(coin_total_c);
                    end else begin
                        out_n.coin_reject = 1'b1;
                    end
                end
                credit_n = credit_acc_c;
                if (credit_acc_c >= CREDIT_W'(PRICE)) begin
                    state_n = ST_VEND;
                end else if (cancel && (credit_acc_c != '0)) begin
                    state_n = ST_CHANGE;
                end else if (credit_acc_c != '0) begin
                    state_n = ST_COLLECT;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_VEND: begin
                out_n.coin_reject = coin_any_c;
                if (vend_ack) begin
                    credit_n = credit_q - CREDIT_W'(PRICE);
                    state_n  = (credit_n != '0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                    // Abort keeps the whole credit so the user gets a full refund
                    if (timer_n == TIMER_W'(ACK_TIMEOUT)) begin
                        out_n.fault = 1'b1;
                        state_n     = ST_CHANGE;
                    end
                end
            end

            ST_CHANGE: begin
                out_n.coin_reject = coin_any_c;
                if (pulse_c) begin
                    out_n.change_pulse = 1'b1;
                    credit_n           = credit_dec_c;
                    if (pulse_done_c) begin
                        state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        pulse_start_c  = (state_n == ST_CHANGE) && (state != ST_CHANGE);
        out_n.vend_req = (state_n == ST_VEND);
        out_n.coin_en  = is_open(state_n);
    end

    assign coin_en      = out_q.coin_en;
    assign coin_reject  = out_q.coin_reject;
    assign vend_req     = out_q.vend_req;
    assign change_pulse = out_q.change_pulse;
    assign fault        = out_q.fault;
    assign credit       = credit_q;

endmodule

// File: tb/tb_vendor_dispense_ctrl.sv
// Scoreboard bench: stimulus queues the expected output changes, a negedge
// monitor pops and compares each observed change together with its cycle spacing.
module tb_vendor_dispense_ctrl;

    localparam int unsigned CW = 6;

    typedef struct packed {
        logic          en;
        logic          rej;
        logic          req;
        logic          cp;
        logic          flt;
        logic [CW-1:0] cr;
    } snap_t;

    typedef struct {
        string       tag;
        snap_t       s;
        int unsigned gap;   // cycles since previous change; 0 = not checked
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          c5_a, c10_a, cancel_a, ack_a;
    logic          en_a, rej_a, req_a, cp_a, flt_a;
    logic [CW-1:0] cr_a;
    logic          c5_b, c10_b, cancel_b, ack_b;
    logic          en_b, rej_b, req_b, cp_b, flt_b;
    logic [CW-1:0] cr_b;

    vendor_dispense_ctrl dut_a (
        .clk(clk), .rst(rst), .coin5(c5_a), .coin10(c10_a), .cancel(cancel_a),
        .vend_ack(ack_a), .coin_en(en_a), .coin_reject(rej_a), .vend_req(req_a),
        .change_pulse(cp_a), .credit(cr_a), .fault(flt_a)
    );

    vendor_dispense_ctrl #(.PRICE(45), .MAX_CREDIT(40)) dut_b (
        .clk(clk), .rst(rst), .coin5(c5_b), .coin10(c10_b), .cancel(cancel_b),
        .vend_ack(ack_b), .coin_en(en_b), .coin_reject(rej_b), .vend_req(req_b),
        .change_pulse(cp_b), .credit(cr_b), .fault(flt_b)
    );

    snap_t snap_a, snap_b;
    assign snap_a = {en_a, rej_a, req_a, cp_a, flt_a, cr_a};
    assign snap_b = {en_b, rej_b, req_b, cp_b, flt_b, cr_b};

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    bit          sel     = 1'b0;
    int unsigned cyc      = 0;
    int unsigned last_cyc = 0;
    snap_t       prev;

    function automatic snap_t mk(input logic en, input logic rej, input logic req,
                                 input logic cp, input logic flt, input int cr);
        snap_t s;
        s = {en, rej, req, cp, flt, CW'(cr)};
        return s;
    endfunction

    // Monitor: every change of the selected DUT's outputs is one scored event
    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        cur = sel ? snap_b : snap_a;
        cyc++;
        if (mon_en && (cur !== prev)) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got en=%b rej=%b req=%b cp=%b flt=%b cr=%0d, required no change",
                         cur.en, cur.rej, cur.req, cur.cp, cur.flt, cur.cr);
            end else begin
                e = q.pop_front();
                if ((cur !== e.s) || ((e.gap != 0) && (cyc - last_cyc != e.gap))) begin
                    n_fail++;
                    $display("FAIL %s: got en=%b rej=%b req=%b cp=%b flt=%b cr=%0d gap=%0d, required en=%b rej=%b req=%b cp=%b flt=%b cr=%0d gap=%0d",
                             e.tag, cur.en, cur.rej, cur.req, cur.cp, cur.flt, cur.cr, cyc - last_cyc,
                             e.s.en, e.s.rej, e.s.req, e.s.cp, e.s.flt, e.s.cr, e.gap);
                end
            end
            last_cyc = cyc;
        end
        prev = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input snap_t s, input int unsigned gap);
        exp_t e;
        e.tag = tag;
        e.s   = s;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned n;
        n = 0;
        while ((q.size() != 0) && (n < bound)) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d events outstanding, required 0", q.size());
            q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic check_reset(input string tag, input snap_t got);
        n_tests++;
        if (got !== mk(1, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL %s: got en=%b rej=%b req=%b cp=%b flt=%b cr=%0d, required en=1 others 0",
                     tag, got.en, got.rej, got.req, got.cp, got.flt, got.cr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        {c5_a, c10_a, cancel_a, ack_a} = '0;
        {c5_b, c10_b, cancel_b, ack_b} = '0;
        repeat (3) tick();
        check_reset("reset_a", snap_a);
        check_reset("reset_b", snap_b);
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();

        // 1: two coin10, ack on third VEND cycle, one change pulse
        push("t1_coin10_a", mk(1, 0, 0, 0, 0, 10), 0);
        push("t1_coin10_b", mk(0, 0, 1, 0, 0, 20), 1);
        push("t1_ack",      mk(0, 0, 0, 0, 0, 5),  3);
        push("t1_pulse",    mk(1, 0, 0, 1, 0, 0),  1);
        push("t1_gap",      mk(1, 0, 0, 0, 0, 0),  1);
        c10_a = 1'b1; tick(); tick(); c10_a = 1'b0;
        tick(); tick();
        ack_a = 1'b1; tick(); ack_a = 1'b0;
        drain(20);

        // 2: coin5+coin10 together reaches price exactly
        push("t2_both",  mk(0, 0, 1, 0, 0, 15), 0);
        push("t2_ack",   mk(1, 0, 0, 0, 0, 0),  1);
        c5_a = 1'b1; c10_a = 1'b1; tick();
        c5_a = 1'b0; c10_a = 1'b0; ack_a = 1'b1; tick(); ack_a = 1'b0;
        drain(20);

        // 3: price above ceiling, overflow reject, cancel refund of 40
        sel = 1'b1;
        push("t3_c10_1", mk(1, 0, 0, 0, 0, 10), 0);
        push("t3_c10_2", mk(1, 0, 0, 0, 0, 20), 1);
        push("t3_c10_3", mk(1, 0, 0, 0, 0, 30), 1);
        push("t3_c10_4", mk(1, 0, 0, 0, 0, 40), 1);
        push("t3_reject", mk(1, 1, 0, 0, 0, 40), 1);
        push("t3_cancel", mk(0, 0, 0, 0, 0, 40), 1);
        for (int k = 1; k <= 8; k++) begin
            push($sformatf("t3_pulse%0d", k), mk(k == 8, 0, 0, 1, 0, 40 - 5 * k), 1);
            push($sformatf("t3_gap%0d", k),   mk(k == 8, 0, 0, 0, 0, 40 - 5 * k), 1);
        end
        c10_b = 1'b1; repeat (5) tick(); c10_b = 1'b0;
        cancel_b = 1'b1; tick(); cancel_b = 1'b0;
        drain(40);
        sel = 1'b0;
        tick();

        // 4: no ack, timeout after 16 request cycles, refund 20 with fault
        push("t4_c10_1", mk(1, 0, 0, 0, 0, 10), 0);
        push("t4_c10_2", mk(0, 0, 1, 0, 0, 20), 1);
        push("t4_timeout", mk(0, 0, 0, 0, 1, 20), 16);
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("t4_pulse%0d", k), mk(k == 4, 0, 0, 1, 1, 20 - 5 * k), 1);
            push($sformatf("t4_gap%0d", k),   mk(k == 4, 0, 0, 0, 1, 20 - 5 * k), 1);
        end
        c10_a = 1'b1; tick(); tick(); c10_a = 1'b0;
        drain(60);

        // 5: off-edge reset glitch ignored, edge-sampled reset in VEND clears all
        push("t5_c10_1", mk(1, 0, 0, 0, 1, 10), 0);
        push("t5_c10_2", mk(0, 0, 1, 0, 1, 20), 1);
        push("t5_reset", mk(1, 0, 0, 0, 0, 0),  2);
        c10_a = 1'b1; tick(); tick(); c10_a = 1'b0;
        rst = 1'b0; #2; rst = 1'b1;
        tick();
        rst = 1'b0; tick(); rst = 1'b1;
        drain(20);

        // 6: coin5 during change is rejected, decrement unaffected
        push("t6_c10",    mk(1, 0, 0, 0, 0, 10), 0);
        push("t6_both",   mk(0, 0, 1, 0, 0, 25), 1);
        push("t6_ack",    mk(0, 0, 0, 0, 0, 10), 1);
        push("t6_rej_p1", mk(0, 1, 0, 1, 0, 5),  1);
        push("t6_gap1",   mk(0, 0, 0, 0, 0, 5),  1);
        push("t6_pulse2", mk(1, 0, 0, 1, 0, 0),  1);
        push("t6_gap2",   mk(1, 0, 0, 0, 0, 0),  1);
        c10_a = 1'b1; tick();
        c5_a = 1'b1; tick();
        c5_a = 1'b0; c10_a = 1'b0; ack_a = 1'b1; tick();
        ack_a = 1'b0; c5_a = 1'b1; tick(); c5_a = 1'b0;
        drain(20);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
